// File: rtl/seq_pat_counter_if.sv
// Handshake bundle between the switch sequence driver and the pattern counter.
// The payload/strobe inputs come from the driver; the hit/count outputs go to display logic.
interface seq_pat_counter_if #(
  parameter int CNT_W = 8
);
  logic             EN;
  logic             X;
  logic             SOF;
  logic             CLR;
  logic             DETECT;
  logic [CNT_W-1:0] COUNT;
  logic             SAT;
  logic             FILLED;

  modport master (
    output EN, X, SOF, CLR,
    input  DETECT, COUNT, SAT, FILLED
  );

  modport slave (
    input  EN, X, SOF, CLR,
    output DETECT, COUNT, SAT, FILLED
  );
endinterface

// File: rtl/seq_pat_counter.sv
// Serial pattern detector with overlap, optional frame alignment and a saturating hit counter.
// A small FSM tracks whether the history window holds PAT_W valid bits.
module seq_pat_counter #(
  parameter int                   PAT_W       = 4,
  parameter logic [PAT_W-1:0]     PATTERN     = 4'b1101,
  parameter int                   CNT_W       = 8,
  parameter bit                   FRAME_ALIGN = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  seq_pat_counter_if.slave bus
);

  localparam int                FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]     FILL_FULL = FW'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {S_FILL, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d, hist_n;
  logic [FW-1:0]    fill_q, fill_d, fill_n;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             det_q, det_d;
  logic             aligned;
  logic             hit;

  // Candidate history/fill if the current bit is accepted.
  always_comb begin
    aligned = FRAME_ALIGN && bus.SOF;
    hist_n  = '0;
    if (!aligned) begin
      for (int i = 1; i < PAT_W; i++) hist_n[i] = hist_q[i-1];
    end
    hist_n[0] = bus.X;
    if (aligned)                 fill_n = FW'(1);
    else if (fill_q == FILL_FULL) fill_n = FILL_FULL;
    else                         fill_n = fill_q + FW'(1);
    hit = (fill_n == FILL_FULL) && (hist_n == PATTERN);
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    count_d = count_q;
    sat_d   = sat_q;
    det_d   = 1'b0;
    if (bus.CLR) begin
      state_d = S_FILL;
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else if (bus.EN) begin
      hist_d = hist_n;
      fill_d = fill_n;
      unique case (state_q)
        S_FILL: if (fill_n == FILL_FULL)   state_d = S_RUN;
        S_RUN:  if (aligned && PAT_W > 1)  state_d = S_FILL;
        default:                           state_d = S_FILL;
      endcase
      if (hit) begin
        det_d = 1'b1;
        if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
        // SAT flags the hit that lands the counter on its maximum.
        if (count_q >= CNT_MAX - CNT_W'(1)) sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      det_q   <= det_d;
    end
  end

  assign bus.DETECT = det_q;
  assign bus.COUNT  = count_q;
  assign bus.SAT    = sat_q;
  assign bus.FILLED = (state_q == S_RUN);

endmodule

// File: tb/tb_seq_pat_counter.sv
// Bench for seq_pat_counter: four parameterisations share one stimulus stream and are
// compared every cycle against a queue-based model, plus hand-computed literal checks.
module tb_seq_pat_counter;
  localparam int NI = 4;
  localparam int       PW [NI] = '{4, 4, 4, 1};
  localparam bit [7:0] PT [NI] = '{8'h0D, 8'h0D, 8'h0D, 8'h01};
  localparam int       CM [NI] = '{255, 255, 3, 7};
  localparam bit       FA [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, x = 1'b0, sof = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  seq_pat_counter_if #(.CNT_W(8)) if0 ();
  seq_pat_counter_if #(.CNT_W(8)) if1 ();
  seq_pat_counter_if #(.CNT_W(2)) if2 ();
  seq_pat_counter_if #(.CNT_W(3)) if3 ();

  assign if0.EN = en; assign if0.X = x; assign if0.SOF = sof; assign if0.CLR = clr;
  assign if1.EN = en; assign if1.X = x; assign if1.SOF = sof; assign if1.CLR = clr;
  assign if2.EN = en; assign if2.X = x; assign if2.SOF = sof; assign if2.CLR = clr;
  assign if3.EN = en; assign if3.X = x; assign if3.SOF = sof; assign if3.CLR = clr;

  seq_pat_counter #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8), .FRAME_ALIGN(1'b0))
    u0 (.CLK(clk), .RST(rst), .bus(if0));
  seq_pat_counter #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8), .FRAME_ALIGN(1'b1))
    u1 (.CLK(clk), .RST(rst), .bus(if1));
  seq_pat_counter #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(2), .FRAME_ALIGN(1'b0))
    u2 (.CLK(clk), .RST(rst), .bus(if2));
  seq_pat_counter #(.PAT_W(1), .PATTERN(1'b1), .CNT_W(3), .FRAME_ALIGN(1'b1))
    u3 (.CLK(clk), .RST(rst), .bus(if3));

  logic       d_det [NI];
  logic [7:0] d_cnt [NI];
  logic       d_sat [NI];
  logic       d_fil [NI];
  assign d_det[0] = if0.DETECT; assign d_cnt[0] = if0.COUNT;
  assign d_sat[0] = if0.SAT;    assign d_fil[0] = if0.FILLED;
  assign d_det[1] = if1.DETECT; assign d_cnt[1] = if1.COUNT;
  assign d_sat[1] = if1.SAT;    assign d_fil[1] = if1.FILLED;
  assign d_det[2] = if2.DETECT; assign d_cnt[2] = 8'(if2.COUNT);
  assign d_sat[2] = if2.SAT;    assign d_fil[2] = if2.FILLED;
  assign d_det[3] = if3.DETECT; assign d_cnt[3] = 8'(if3.COUNT);
  assign d_sat[3] = if3.SAT;    assign d_fil[3] = if3.FILLED;

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: keep the last PAT_W accepted bits (since clear/aligned SOF) and match them directly.
  bit mq [NI][$];
  int m_cnt [NI];
  bit m_sat [NI];
  bit m_det [NI];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      bit [7:0] p;
      bit       match;
      p = PT[i];
      m_det[i] = 1'b0;
      if (rst || clr) begin
        mq[i].delete();
        m_cnt[i] = 0;
        m_sat[i] = 1'b0;
      end else if (en) begin
        if (FA[i] && sof) mq[i].delete();
        mq[i].push_back(x);
        if (mq[i].size() > PW[i]) void'(mq[i].pop_front());
        if (mq[i].size() == PW[i]) begin
          match = 1'b1;
          for (int k = 0; k < PW[i]; k++)
            if (mq[i][k] != p[PW[i]-1-k]) match = 1'b0;
          if (match) begin
            m_det[i] = 1'b1;
            if (m_cnt[i] < CM[i]) m_cnt[i]++;
            if (m_cnt[i] == CM[i]) m_sat[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d_detect", i), 32'(d_det[i]), 32'(m_det[i]));
      chk($sformatf("u%0d_count", i),  32'(d_cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("u%0d_sat", i),    32'(d_sat[i]), 32'(m_sat[i]));
      chk($sformatf("u%0d_filled", i), 32'(d_fil[i]), 32'(mq[i].size() == PW[i]));
    end
  end

  task automatic step(input logic e, input logic xv, input logic s, input logic c);
    en = e; x = xv; sof = s; clr = c;
    @(posedge clk); #1;
  endtask
  task automatic bitin(input logic xv, input logic s = 1'b0);
    step(1'b1, xv, s, 1'b0);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [2:0] vt [0:19];

  initial begin
    // Reset asserted away from any edge must clear outputs immediately.
    #2 rst = 1'b1;
    #1;
    chk("t1_count0",  32'(if0.COUNT),  0);
    chk("t1_detect0", 32'(if0.DETECT), 0);
    chk("t1_sat0",    32'(if0.SAT),    0);
    chk("t1_filled0", 32'(if0.FILLED), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // Overlapping hits in 1101101.
    bitin(1); bitin(1); bitin(0);
    chk("t2_filled_bit3", 32'(if0.FILLED), 0);
    bitin(1);
    chk("t2_det_bit4",    32'(if0.DETECT), 1);
    chk("t2_filled_bit4", 32'(if0.FILLED), 1);
    bitin(1); bitin(0);
    chk("t2_det_bit6",    32'(if0.DETECT), 0);
    bitin(1);
    chk("t2_det_bit7",    32'(if0.DETECT), 1);
    chk("t2_count",       32'(if0.COUNT),  2);
    idle(1);
    chk("t2_det_after",   32'(if0.DETECT), 0);

    // Gaps of EN=0 between bits do not disturb matching.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bitin(1); idle(3); bitin(1); idle(3); bitin(0); idle(3);
    chk("t3_no_early_det", 32'(if0.COUNT), 0);
    bitin(1);
    chk("t3_det",   32'(if0.DETECT), 1);
    chk("t3_count", 32'(if0.COUNT),  1);
    idle(1);
    chk("t3_single_pulse", 32'(if0.DETECT), 0);

    // Frame alignment: 1,1 | SOF 0,1 must not hit in the aligned instance.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bitin(1); bitin(1); bitin(0, 1'b1); bitin(1);
    chk("t4_aligned_nohit", 32'(if1.COUNT),  0);
    chk("t4_aligned_fill2", 32'(if1.FILLED), 0);
    chk("t4_unaligned_hit", 32'(if0.COUNT),  1);
    bitin(1, 1'b1); bitin(1); bitin(0); bitin(1);
    chk("t4_aligned_det",   32'(if1.DETECT), 1);
    chk("t4_aligned_count", 32'(if1.COUNT),  1);

    // Saturation of the 2-bit counter.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bitin(1); bitin(1); bitin(0); bitin(1);
    bitin(1); bitin(0); bitin(1);
    chk("t5_cnt2", 32'(if2.COUNT), 2);
    chk("t5_sat0", 32'(if2.SAT),   0);
    bitin(1); bitin(0); bitin(1);
    chk("t5_cnt3", 32'(if2.COUNT), 3);
    chk("t5_sat1", 32'(if2.SAT),   1);
    bitin(1); bitin(0); bitin(1);
    chk("t5_det4",  32'(if2.DETECT), 1);
    chk("t5_held3", 32'(if2.COUNT),  3);
    chk("t5_sticky", 32'(if2.SAT),   1);

    // Mid-cycle asynchronous reset with nonzero state.
    #3 rst = 1'b1;
    #1;
    chk("t1b_count0", 32'(if0.COUNT),  0);
    chk("t1b_sat0",   32'(if2.SAT),    0);
    chk("t1b_filled", 32'(if0.FILLED), 0);
    @(posedge clk); #1 rst = 1'b0;

    // CLR together with the completing bit discards it.
    bitin(1); bitin(1); bitin(0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_det0",    32'(if0.DETECT), 0);
    chk("t6_count0",  32'(if0.COUNT),  0);
    chk("t6_filled0", 32'(if0.FILLED), 0);
    chk("t6_pw1_det0", 32'(if3.DETECT), 0);
    bitin(1);
    chk("t6_restart_nodet", 32'(if0.DETECT), 0);

    // Mixed vectors {EN, X, SOF} checked only by the model.
    vt = '{3'b110, 3'b111, 3'b000, 3'b100, 3'b110, 3'b110, 3'b011, 3'b100,
           3'b110, 3'b111, 3'b110, 3'b100, 3'b110, 3'b101, 3'b110, 3'b100,
           3'b000, 3'b110, 3'b110, 3'b111};
    for (int v = 0; v < 20; v++) step(vt[v][2], vt[v][1], vt[v][0], 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
